mio_responder: RTL and testbench

MIO_RESPONDER -- requirements
Module: mio_responder

---
 rtl/mio_pkg.sv | 15 +
 rtl/mio_ram.sv | 20 ++
 rtl/mio_responder.sv | 129 ++++++++++++
 tb/tb_mio_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// Shared definitions for the memory/IO responder: region decode on addr[31:28]
// and the responder state encoding.
package mio_pkg;

  localparam logic [3:0] REGION_RAM  = 4'h0;
  localparam logic [3:0] REGION_GPIO = 4'hE;
  localparam logic [3:0] REGION_CNT  = 4'hF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_WAIT = 2'd1,
    RESP     = 2'd2
  } state_t;

endpackage

// File: rtl/mio_ram.sv
// Single-port word RAM: synchronous write, registered read, contents not reset.
module mio_ram #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mio_responder.sv
// CPU memory/IO responder: decodes RAM, GPIO and a free-running counter,
// and answers every request with a single-cycle ready pulse.
module mio_responder
  import mio_pkg::*;
#(
  parameter int RAM_LAT   = 2,
  parameter int RAM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output state_t      dbg_state
);

  // Handshake: the CPU raises req with addr/we/wdata and holds them stable
  // until ready; ready is high for exactly one cycle (RESP), in which rdata is
  // valid for reads. A req still high in the following IDLE is a new access.

  localparam int         AW        = $clog2(RAM_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(RAM_LAT - 1);

  logic [3:0] region;
  logic       is_ram, is_gpio, is_cnt;

  assign region  = addr[31:28];
  assign is_ram  = (region == REGION_RAM);
  assign is_gpio = (region == REGION_GPIO);
  assign is_cnt  = (region == REGION_CNT);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (is_ram) begin
            state_d = RAM_WAIT;
            wait_d  = WAIT_INIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      RAM_WAIT: begin
        if (wait_q == 4'd0) state_d = RESP;
        else                wait_d  = wait_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready     = (state_q == RESP);
  assign dbg_state = state_q;

  // Writes land on the edge that ends RESP; a reset on that edge drops them.
  logic commit;
  assign commit = (state_q == RESP) && we && !reset;

  logic [31:0] ram_q;
  logic [31:0] cnt_q;
  logic [15:0] led_q;
  logic [31:0] rdata_q;

  mio_ram #(
    .WORDS (RAM_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (commit && is_ram),
    .addr  (addr[AW+1:2]),
    .wdata (wdata),
    .rdata (ram_q)
  );

  // rdata is loaded on the edge entering RESP so it is valid with ready. The
  // RAM read port follows addr every cycle, so ram_q is settled by then.
  logic        load_rd;
  logic [31:0] rd_next;

  assign load_rd = !we && (((state_q == IDLE) && req && !is_ram) ||
                           ((state_q == RAM_WAIT) && (wait_q == 4'd0)));

  always_comb begin
    rd_next = 32'h0;
    if (is_ram)       rd_next = ram_q;
    else if (is_gpio) rd_next = {16'h0, sw_in};
    else if (is_cnt)  rd_next = cnt_q + 32'd1;  // the value the counter holds in RESP
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 32'h0;
      led_q   <= 16'h0;
      cnt_q   <= 32'h0;
    end else begin
      if (load_rd)           rdata_q <= rd_next;
      if (commit && is_gpio) led_q   <= wdata[15:0];
      if (commit && is_cnt)  cnt_q   <= wdata;
      else                   cnt_q   <= cnt_q + 32'd1;
    end
  end

  assign rdata   = rdata_q;
  assign led_out = led_q;

  logic unused_addr;
  assign unused_addr = ^addr;

endmodule

// File: tb/tb_mio_responder.sv
// Bench for mio_responder: vector table of single accesses plus hand-written
// sequences for counter wrap, held req and reset mid-access.
module tb_mio_responder;
  import mio_pkg::*;

  localparam int RAM_LAT   = 2;
  localparam int RAM_WORDS = 1024;
  localparam int LAT_RAM   = RAM_LAT + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  state_t      dbg_state;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [15:0] sw;
    logic [31:0] exp_d;
    int          lat;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[14];

  mio_responder #(
    .RAM_LAT   (RAM_LAT),
    .RAM_WORDS (RAM_WORDS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .sw_in     (sw_in),
    .led_out   (led_out),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called in a cycle where ready is high.
  task automatic sb_resp(input logic w);
    logic [31:0] e;
    if (w) begin
      check("rdata_hold_on_write", rdata, last_rd);
    end else if (exp_q.size() == 0) begin
      check("sb_unexpected_read", 32'h1, 32'h0);
    end else begin
      e = exp_q.pop_front();
      check("rdata", rdata, e);
      last_rd = e;
    end
  endtask

  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_d, input int exp_lat, output int resp_cyc);
    int   lat;
    logic got;
    req = 1'b1; we = w; addr = a; wdata = d;
    if (!w) exp_q.push_back(exp_d);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (ready) got = 1'b1;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    resp_cyc = cyc;
    if (got) sb_resp(w);
    req = 1'b0;
    @(negedge clk);
    check("ready_one_cycle", {31'h0, ready}, 32'h0);
  endtask

  initial begin
    int          rc;
    int          w_cyc;
    int          pulses;
    int          last_pulse;
    int          k;
    int          extra;
    logic [31:0] exp_cnt;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0000, 32'h0,         LAT_RAM, 16'h0000};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         16'h0000, 32'hDEAD_BEEF, LAT_RAM, 16'h0000};
    vecs[2]  = '{1'b1, 32'hE000_0000, 32'h0000_A5A5, 16'h0000, 32'h0,         1,       16'hA5A5};
    vecs[3]  = '{1'b0, 32'hE000_0000, 32'h0,         16'h1234, 32'h0000_1234, 1,       16'hA5A5};
    vecs[4]  = '{1'b0, 32'h5000_0000, 32'h0,         16'h1234, 32'h0,         1,       16'hA5A5};
    vecs[5]  = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 16'h1234, 32'h0,         LAT_RAM, 16'hA5A5};
    vecs[6]  = '{1'b1, 32'h5000_0000, 32'hFFFF_FFFF, 16'h1234, 32'h0,         1,       16'hA5A5};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         16'h1234, 32'h0BAD_F00D, LAT_RAM, 16'hA5A5};
    vecs[8]  = '{1'b0, 32'h0000_0010, 32'h0,         16'h1234, 32'hDEAD_BEEF, LAT_RAM, 16'hA5A5};
    vecs[9]  = '{1'b1, 32'h0000_0044, 32'h1234_5678, 16'h1234, 32'h0,         LAT_RAM, 16'hA5A5};
    vecs[10] = '{1'b0, 32'h0000_0047, 32'h0,         16'h1234, 32'h1234_5678, LAT_RAM, 16'hA5A5};
    vecs[11] = '{1'b1, 32'hE000_0004, 32'hFFFF_5A3C, 16'h1234, 32'h0,         1,       16'h5A3C};
    vecs[12] = '{1'b0, 32'hE000_0008, 32'h0,         16'hBEEF, 32'h0000_BEEF, 1,       16'h5A3C};
    vecs[13] = '{1'b1, 32'h0000_0020, 32'h2222_2222, 16'hBEEF, 32'h0,         LAT_RAM, 16'h5A3C};

    reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; sw_in = 16'h0;
    last_rd = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'h0, ready}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_led", {16'h0, led_out}, 32'h0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      sw_in = vecs[i].sw;
      do_access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_d, vecs[i].lat, rc);
      check("led_out", {16'h0, led_out}, {16'h0, vecs[i].exp_led});
    end

    // Counter wrap: reads land two and more cycles after the load commits.
    do_access(1'b1, 32'hF000_0000, 32'hFFFF_FFFE, 32'h0, 1, w_cyc);
    @(negedge clk);
    exp_cnt = 32'hFFFF_FFFE + 32'(cyc - w_cyc);
    do_access(1'b0, 32'hF000_0000, 32'h0, exp_cnt, 1, rc);
    exp_cnt = 32'hFFFF_FFFE + 32'(cyc - w_cyc);
    do_access(1'b0, 32'hF000_0000, 32'h0, exp_cnt, 1, rc);

    // req held high across three RAM reads.
    req = 1'b1; we = 1'b0; addr = 32'h0000_0010;
    repeat (3) exp_q.push_back(32'hDEAD_BEEF);
    pulses = 0; last_pulse = 0; k = 0;
    while (pulses < 3 && k < 40) begin
      @(negedge clk);
      k++;
      if (ready) begin
        pulses++;
        if (pulses == 1) check("held_first_lat", 32'(k), 32'(LAT_RAM));
        else             check("held_gap", 32'(k - last_pulse), 32'(LAT_RAM + 1));
        last_pulse = k;
        sb_resp(1'b0);
        if (pulses == 3) req = 1'b0;
      end
    end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (ready) extra++;
    end
    check("held_pulse_count", 32'(pulses + extra), 32'd3);

    // Reset during RAM_WAIT of a write; req held through reset as a counter read.
    req = 1'b1; we = 1'b1; addr = 32'h0000_0020; wdata = 32'h1111_1111;
    @(negedge clk);
    check("abort_in_wait", 32'(dbg_state), 32'(RAM_WAIT));
    @(negedge clk);
    check("abort_no_ready_pre", {31'h0, ready}, 32'h0);
    reset = 1'b1; we = 1'b0; addr = 32'hF000_0000; wdata = 32'h0;
    @(negedge clk);
    check("abort_no_ready", {31'h0, ready}, 32'h0);
    check("abort_rdata", rdata, 32'h0);
    check("abort_led", {16'h0, led_out}, 32'h0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    last_rd = 32'h0;
    reset = 1'b0;
    do_access(1'b0, 32'hF000_0000, 32'h0, 32'h0000_0001, 1, rc);
    do_access(1'b0, 32'h0000_0020, 32'h0, 32'h2222_2222, LAT_RAM, rc);

    check("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
